// File: rtl/axi2mem_trans_arbiter.sv
// Shares the two-lane TCDM command port between the read and write transaction generators.
// Zero-latency combinational mux; the grant follows trans_gnt_i, whole bursts are locked, and read bursts in flight are capped.
module axi2mem_trans_arbiter #(
   parameter int ID_WIDTH           = 6,
   parameter int ADDR_WIDTH         = 32,
   parameter int MAX_RD_OUTSTANDING = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    rd_pend_i,
   input  logic [2*ID_WIDTH-1:0]   rd_id_i,
   input  logic [2*ADDR_WIDTH-1:0] rd_add_i,
   input  logic [1:0]              rd_req_i,
   input  logic [1:0]              rd_last_i,
   output logic [1:0]              rd_gnt_o,
   input  logic                    wr_pend_i,
   input  logic [2*ID_WIDTH-1:0]   wr_id_i,
   input  logic [2*ADDR_WIDTH-1:0] wr_add_i,
   input  logic [1:0]              wr_req_i,
   input  logic [1:0]              wr_last_i,
   output logic [1:0]              wr_gnt_o,
   input  logic                    rd_burst_done_i,
   output logic [2*ID_WIDTH-1:0]   trans_id_o,
   output logic [2*ADDR_WIDTH-1:0] trans_add_o,
   output logic [1:0]              trans_we_o,
   output logic [1:0]              trans_req_o,
   output logic [1:0]              trans_last_o,
   input  logic [1:0]              trans_gnt_i
);

   localparam int CW = $clog2(MAX_RD_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCK_RD = 2'd1,
      LOCK_WR = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            ptr_q, ptr_d;      // 0 = read has priority, 1 = write
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            rd_elig;
   logic            sel_rd, sel_wr;
   logic            port_ok;
   logic            beat, beat_last, rd_inc;
   logic [1:0]      sel_req, sel_last;

   // Winner selection never looks at req, so gnt cannot loop back through the generators.
   always_comb begin
      rd_elig = rd_pend_i && (cnt_q < CW'(MAX_RD_OUTSTANDING));
      sel_rd  = 1'b0;
      sel_wr  = 1'b0;
      case (state_q)
         IDLE: begin
            sel_rd = rd_elig && (!wr_pend_i || !ptr_q);
            sel_wr = wr_pend_i && (!rd_elig || ptr_q);
         end
         LOCK_RD: sel_rd = 1'b1;
         LOCK_WR: sel_wr = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      port_ok   = (trans_gnt_i == 2'b11);
      sel_req   = 2'b00;
      sel_last  = 2'b00;
      if (sel_rd) begin
         sel_req  = rd_req_i;
         sel_last = rd_last_i;
      end else if (sel_wr) begin
         sel_req  = wr_req_i;
         sel_last = wr_last_i;
      end
      beat      = (sel_req == 2'b11) && port_ok;
      beat_last = beat && (&sel_last);
      rd_inc    = beat_last && sel_rd;
   end

   // Outputs forced low while reset is held so an abandoned burst leaves the port at once.
   always_comb begin
      rd_gnt_o     = 2'b00;
      wr_gnt_o     = 2'b00;
      trans_id_o   = '0;
      trans_add_o  = '0;
      trans_we_o   = 2'b00;
      trans_req_o  = 2'b00;
      trans_last_o = 2'b00;
      if (!rst_i) begin
         if (sel_rd && port_ok) rd_gnt_o = trans_gnt_i;
         if (sel_wr && port_ok) wr_gnt_o = trans_gnt_i;
         if (sel_rd) begin
            trans_id_o   = rd_id_i;
            trans_add_o  = rd_add_i;
            trans_last_o = rd_last_i;
         end else if (sel_wr) begin
            trans_id_o   = wr_id_i;
            trans_add_o  = wr_add_i;
            trans_we_o   = 2'b11;
            trans_last_o = wr_last_i;
         end
         if (sel_req == 2'b11) trans_req_o = 2'b11;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      if (beat_last) begin
         state_d = IDLE;
         ptr_d   = sel_rd;
      end else if (beat) begin
         state_d = sel_rd ? LOCK_RD : LOCK_WR;
      end
      if (rd_inc && !rd_burst_done_i) begin
         cnt_d = cnt_q + CW'(1);
      end else if (rd_burst_done_i && !rd_inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

`ifndef SYNTHESIS
   a_partial_req: assert property (@(posedge clk_i) disable iff (rst_i)
      (sel_req != 2'b01) && (sel_req != 2'b10));
   a_done_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      rd_burst_done_i |-> ((cnt_q != '0) || rd_inc));
`endif

endmodule

// File: tb/tb_axi2mem_trans_arbiter.sv
// Directed bench for axi2mem_trans_arbiter: burst locking, fairness, stalls, outstanding cap and reset.
module tb_axi2mem_trans_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rd_pend_i, wr_pend_i, rd_burst_done_i;
   logic [11:0] rd_id_i, wr_id_i, trans_id_o;
   logic [63:0] rd_add_i, wr_add_i, trans_add_o;
   logic [1:0]  rd_req_i, rd_last_i, rd_gnt_o;
   logic [1:0]  wr_req_i, wr_last_i, wr_gnt_o;
   logic [1:0]  trans_we_o, trans_req_o, trans_last_o, trans_gnt_i;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_i = ~clk_i;

   axi2mem_trans_arbiter #(
      .ID_WIDTH(6), .ADDR_WIDTH(32), .MAX_RD_OUTSTANDING(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .rd_pend_i(rd_pend_i), .rd_id_i(rd_id_i), .rd_add_i(rd_add_i),
      .rd_req_i(rd_req_i), .rd_last_i(rd_last_i), .rd_gnt_o(rd_gnt_o),
      .wr_pend_i(wr_pend_i), .wr_id_i(wr_id_i), .wr_add_i(wr_add_i),
      .wr_req_i(wr_req_i), .wr_last_i(wr_last_i), .wr_gnt_o(wr_gnt_o),
      .rd_burst_done_i(rd_burst_done_i),
      .trans_id_o(trans_id_o), .trans_add_o(trans_add_o), .trans_we_o(trans_we_o),
      .trans_req_o(trans_req_o), .trans_last_o(trans_last_o), .trans_gnt_i(trans_gnt_i)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      rd_pend_i = 0; rd_req_i = 0; rd_last_i = 0;
      wr_pend_i = 0; wr_req_i = 0; wr_last_i = 0;
      rd_burst_done_i = 0; trans_gnt_i = 2'b11;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1;
      tick();
      rst_i = 0;
      #1;
   endtask

   task automatic single_read();
      rd_pend_i = 1; rd_req_i = 2'b11; rd_last_i = 2'b11;
      #1;
      check("single_rd_gnt", rd_gnt_o, 2'b11);
      tick();
      rd_pend_i = 0; rd_req_i = 0; rd_last_i = 0;
   endtask

   initial begin
      rd_id_i  = {6'd3, 6'd3};
      wr_id_i  = {6'd9, 6'd9};
      rd_add_i = {32'h0000_0104, 32'h0000_0100};
      wr_add_i = {32'h0000_0204, 32'h0000_0200};
      idle_inputs();
      rst_i = 1;
      #2;
      check("rst_state", dut.state_q, 0);
      check("rst_ptr", dut.ptr_q, 0);
      check("rst_cnt", dut.cnt_q, 0);
      rd_pend_i = 1; rd_req_i = 2'b11; rd_last_i = 2'b11;
      #1;
      check("rst_rd_gnt", rd_gnt_o, 0);
      check("rst_req", trans_req_o, 0);
      check("rst_add", trans_add_o, 0);
      tick();
      rst_i = 0;
      idle_inputs();
      #1;
      check("idle_req", trans_req_o, 0);
      check("idle_id", trans_id_o, 0);

      // Single-beat read, zero latency
      rd_pend_i = 1; rd_req_i = 2'b11; rd_last_i = 2'b11;
      #1;
      check("t1_rd_gnt", rd_gnt_o, 2'b11);
      check("t1_req", trans_req_o, 2'b11);
      check("t1_we", trans_we_o, 2'b00);
      check("t1_add", trans_add_o, 64'h0000_0104_0000_0100);
      check("t1_id", trans_id_o, 12'h0C3);
      check("t1_last", trans_last_o, 2'b11);
      tick();
      check("t1_state", dut.state_q, 0);
      check("t1_cnt", dut.cnt_q, 1);
      check("t1_ptr", dut.ptr_q, 1);

      // Both pending after reset: read burst first, then write burst
      do_reset();
      rd_pend_i = 1; wr_pend_i = 1;
      for (int i = 0; i < 4; i++) begin
         rd_req_i = 2'b11; rd_last_i = (i == 3) ? 2'b11 : 2'b00;
         #1;
         check("t2_rd_gnt", rd_gnt_o, 2'b11);
         check("t2_wr_gnt", wr_gnt_o, 2'b00);
         check("t2_rd_we", trans_we_o, 2'b00);
         tick();
         check("t2_rd_state", dut.state_q, (i == 3) ? 0 : 1);
      end
      rd_pend_i = 0; rd_req_i = 0; rd_last_i = 0;
      check("t2_ptr_wr", dut.ptr_q, 1);
      check("t2_cnt", dut.cnt_q, 1);
      for (int i = 0; i < 4; i++) begin
         wr_req_i = 2'b11; wr_last_i = (i == 3) ? 2'b11 : 2'b00;
         #1;
         check("t2_wr_gnt_w", wr_gnt_o, 2'b11);
         check("t2_rd_gnt_w", rd_gnt_o, 2'b00);
         check("t2_wr_we", trans_we_o, 2'b11);
         check("t2_wr_add", trans_add_o, 64'h0000_0204_0000_0200);
         tick();
      end
      wr_pend_i = 0; wr_req_i = 0; wr_last_i = 0;
      check("t2_ptr_rd", dut.ptr_q, 0);
      check("t2_end_state", dut.state_q, 0);

      // 3-beat write with a 2-cycle partial port grant in beat 2
      wr_pend_i = 1; wr_req_i = 2'b11; wr_last_i = 2'b00;
      #1;
      check("t3_b1_gnt", wr_gnt_o, 2'b11);
      tick();
      check("t3_lock", dut.state_q, 2);
      rd_pend_i = 1; trans_gnt_i = 2'b01;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("t3_stall_wr_gnt", wr_gnt_o, 2'b00);
         check("t3_stall_rd_gnt", rd_gnt_o, 2'b00);
         tick();
         check("t3_stall_state", dut.state_q, 2);
      end
      trans_gnt_i = 2'b11;
      #1;
      check("t3_b2_gnt", wr_gnt_o, 2'b11);
      tick();
      wr_last_i = 2'b11;
      #1;
      check("t3_b3_gnt", wr_gnt_o, 2'b11);
      tick();
      check("t3_end_state", dut.state_q, 0);
      check("t3_cnt", dut.cnt_q, 1);

      // Outstanding cap at 4
      do_reset();
      for (int i = 0; i < 4; i++) single_read();
      check("t4_cnt4", dut.cnt_q, 4);
      rd_pend_i = 1; wr_pend_i = 1;
      #1;
      check("t4_rd_blocked", rd_gnt_o, 2'b00);
      check("t4_wr_gnt", wr_gnt_o, 2'b11);
      wr_req_i = 2'b11; wr_last_i = 2'b11;
      #1;
      check("t4_wr_we", trans_we_o, 2'b11);
      tick();
      wr_pend_i = 0; wr_req_i = 0; wr_last_i = 0;
      rd_burst_done_i = 1;
      #1;
      check("t4_still_blocked", rd_gnt_o, 2'b00);
      tick();
      rd_burst_done_i = 0;
      #1;
      check("t4_cnt3", dut.cnt_q, 3);
      check("t4_rd_gnt_again", rd_gnt_o, 2'b11);
      single_read();
      check("t4_cnt_back4", dut.cnt_q, 4);

      // Simultaneous increment and decrement at count 2
      do_reset();
      single_read();
      single_read();
      check("t5_cnt2", dut.cnt_q, 2);
      rd_burst_done_i = 1;
      single_read();
      check("t5_same_cycle", dut.cnt_q, 2);
      tick();
      rd_burst_done_i = 0;
      check("t5_dec", dut.cnt_q, 1);

      // Reset during beat 2 of an 8-beat read
      do_reset();
      single_read();
      check("t6_pre_ptr", dut.ptr_q, 1);
      rd_pend_i = 1; rd_req_i = 2'b11; rd_last_i = 2'b00;
      tick();
      check("t6_lock", dut.state_q, 1);
      rst_i = 1;
      #1;
      check("t6_rd_gnt", rd_gnt_o, 0);
      check("t6_req", trans_req_o, 0);
      check("t6_add", trans_add_o, 0);
      check("t6_last", trans_last_o, 0);
      check("t6_cnt", dut.cnt_q, 0);
      check("t6_state", dut.state_q, 0);
      tick();
      rst_i = 0;
      idle_inputs();
      #1;
      check("t6_ptr_after", dut.ptr_q, 0);
      check("t6_cnt_after", dut.cnt_q, 0);
      check("t6_state_after", dut.state_q, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
